// File: rtl/ctrl_pkg.sv
// Shared types and constants for the hard-wired controller.
package ctrl_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned SW_W  = 3;
  localparam int unsigned BEAT_W = 3;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_INTR = 2'd2
  } state_t;

  // One-hot beat encoding {W3,W2,W1}; all-zero while halted.
  localparam logic [BEAT_W-1:0] W_OFF = 3'b000;
  localparam logic [BEAT_W-1:0] W1    = 3'b001;
  localparam logic [BEAT_W-1:0] W2    = 3'b010;
  localparam logic [BEAT_W-1:0] W3    = 3'b100;

  // Console modes {swc,swb,swa}.
  localparam logic [SW_W-1:0] SW_RUN  = 3'b000;
  localparam logic [SW_W-1:0] SW_WMEM = 3'b001;
  localparam logic [SW_W-1:0] SW_RMEM = 3'b010;
  localparam logic [SW_W-1:0] SW_RREG = 3'b011;
  localparam logic [SW_W-1:0] SW_WREG = 3'b100;

  // Opcodes occupy the low four bits of ir; any set bit above them means NOP.
  localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0010;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0011;
  localparam logic [OP_W-1:0] OP_INC  = 4'b0100;
  localparam logic [OP_W-1:0] OP_LD   = 4'b0101;
  localparam logic [OP_W-1:0] OP_ST   = 4'b0110;
  localparam logic [OP_W-1:0] OP_JC   = 4'b0111;
  localparam logic [OP_W-1:0] OP_JZ   = 4'b1000;
  localparam logic [OP_W-1:0] OP_JMP  = 4'b1001;
  localparam logic [OP_W-1:0] OP_OR   = 4'b1010;
  localparam logic [OP_W-1:0] OP_DEC  = 4'b1011;
  localparam logic [OP_W-1:0] OP_EI   = 4'b1100;
  localparam logic [OP_W-1:0] OP_DI   = 4'b1101;
  localparam logic [OP_W-1:0] OP_STP  = 4'b1110;
  localparam logic [OP_W-1:0] OP_IRET = 4'b1111;

  typedef struct packed {
    logic       drw;
    logic       pcinc;
    logic       lpc;
    logic       lar;
    logic       pcadd;
    logic       arinc;
    logic       selctl;
    logic       memw;
    logic       lir;
    logic       ldz;
    logic       ldc;
    logic       cin;
    logic [3:0] s;
    logic       m;
    logic       abus;
    logic       sbus;
    logic       mbus;
    logic [3:0] sel;
    logic       int_ack;
    logic       lpc_vec;
    logic       lpc_ret;
  } ctl_t;

endpackage

// File: rtl/ctrl_seq_decode.sv
// Combinational microcontrol decode for the current beat.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned IR_W   = 4,
  parameter int unsigned INT_EN = 1
) (
  input  state_t            i_state,
  input  logic [BEAT_W-1:0] i_w,
  input  logic              i_st0,
  input  logic [SW_W-1:0]   i_sw,
  input  logic [IR_W-1:0]   i_ir,
  input  logic              i_c,
  input  logic              i_z,
  input  logic              i_ie,
  output ctl_t              o_ctl_c,
  output logic              o_short_c,
  output logic              o_long_c,
  output logic              o_stop_c,
  output logic              o_sst0_c,
  output logic              o_cst0_c,
  output logic              o_set_ie_c,
  output logic              o_clr_ie_c
);

  logic [OP_W-1:0] w_op;

  // Opcodes wider than four bits with any upper bit set decode as NOP.
  assign w_op = ((i_ir >> OP_W) != '0) ? OP_NOP : OP_W'(i_ir);

  // Beat decode: control word plus sequencing hints for the FSM.
  always_comb begin
    o_ctl_c    = '0;
    o_short_c  = 1'b0;
    o_long_c   = 1'b0;
    o_stop_c   = 1'b0;
    o_sst0_c   = 1'b0;
    o_cst0_c   = 1'b0;
    o_set_ie_c = 1'b0;
    o_clr_ie_c = 1'b0;
    if (i_state == ST_INTR) begin
      o_ctl_c.int_ack = (INT_EN != 0);
      o_ctl_c.lpc_vec = 1'b1;
    end else if (i_state == ST_RUN) begin
      case (i_sw)
        SW_RUN: begin
          if (!i_st0) begin
            if (i_w == W1) begin
              o_ctl_c.sbus = 1'b1;
              o_ctl_c.lpc  = 1'b1;
              o_short_c    = 1'b1;
              o_sst0_c     = 1'b1;
            end
          end else if (i_w == W1) begin
            o_ctl_c.lir   = (w_op != OP_STP);
            o_ctl_c.pcinc = (w_op != OP_STP);
          end else if (i_w == W2) begin
            case (w_op)
              OP_ADD:  begin o_ctl_c.s = 4'b1001; o_ctl_c.cin = 1'b1; o_ctl_c.abus = 1'b1;
                             o_ctl_c.drw = 1'b1; o_ctl_c.ldz = 1'b1; o_ctl_c.ldc = 1'b1; end
              OP_SUB:  begin o_ctl_c.s = 4'b0110; o_ctl_c.abus = 1'b1;
                             o_ctl_c.drw = 1'b1; o_ctl_c.ldz = 1'b1; o_ctl_c.ldc = 1'b1; end
              OP_AND:  begin o_ctl_c.s = 4'b1011; o_ctl_c.m = 1'b1; o_ctl_c.abus = 1'b1;
                             o_ctl_c.drw = 1'b1; o_ctl_c.ldz = 1'b1; end
              OP_INC:  begin o_ctl_c.s = 4'b0000; o_ctl_c.abus = 1'b1;
                             o_ctl_c.drw = 1'b1; o_ctl_c.ldz = 1'b1; o_ctl_c.ldc = 1'b1; end
              OP_LD:   begin o_ctl_c.s = 4'b1010; o_ctl_c.m = 1'b1; o_ctl_c.abus = 1'b1;
                             o_ctl_c.lar = 1'b1; o_long_c = 1'b1; end
              OP_ST:   begin o_ctl_c.s = 4'b1111; o_ctl_c.m = 1'b1; o_ctl_c.abus = 1'b1;
                             o_ctl_c.lar = 1'b1; o_long_c = 1'b1; end
              OP_JC:   o_ctl_c.pcadd = i_c;
              OP_JZ:   o_ctl_c.pcadd = i_z;
              OP_JMP:  begin o_ctl_c.s = 4'b1111; o_ctl_c.m = 1'b1; o_ctl_c.abus = 1'b1;
                             o_ctl_c.lpc = 1'b1; end
              OP_OR:   begin o_ctl_c.s = 4'b1110; o_ctl_c.m = 1'b1; o_ctl_c.abus = 1'b1;
                             o_ctl_c.drw = 1'b1; o_ctl_c.ldz = 1'b1; end
              OP_DEC:  begin o_ctl_c.s = 4'b1111; o_ctl_c.cin = 1'b1; o_ctl_c.abus = 1'b1;
                             o_ctl_c.drw = 1'b1; o_ctl_c.ldz = 1'b1; o_ctl_c.ldc = 1'b1; end
              OP_EI:   o_set_ie_c = !i_ie;
              OP_DI:   o_clr_ie_c = i_ie;
              OP_IRET: begin o_ctl_c.lpc_ret = 1'b1; o_set_ie_c = !i_ie; end
              OP_STP:  o_stop_c = 1'b1;
              default: ;
            endcase
          end else if (i_w == W3) begin
            if (w_op == OP_LD) begin
              o_ctl_c.mbus = 1'b1;
              o_ctl_c.drw  = 1'b1;
            end else if (w_op == OP_ST) begin
              o_ctl_c.s    = 4'b1010;
              o_ctl_c.m    = 1'b1;
              o_ctl_c.abus = 1'b1;
              o_ctl_c.memw = 1'b1;
            end
          end
        end
        SW_WMEM, SW_RMEM: begin
          o_short_c = 1'b1;
          o_stop_c  = 1'b1;
          if (!i_st0) begin
            o_ctl_c.sbus = 1'b1;
            o_ctl_c.lar  = 1'b1;
            o_sst0_c     = 1'b1;
          end else begin
            o_ctl_c.arinc = 1'b1;
            o_ctl_c.sbus  = (i_sw == SW_WMEM);
            o_ctl_c.memw  = (i_sw == SW_WMEM);
            o_ctl_c.mbus  = (i_sw == SW_RMEM);
          end
        end
        SW_RREG: begin
          o_ctl_c.selctl = 1'b1;
          if (i_w == W1) begin
            o_ctl_c.sel = 4'b0001;
          end else begin
            o_ctl_c.sel = 4'b1011;
            o_stop_c    = 1'b1;
          end
        end
        SW_WREG: begin
          o_ctl_c.sbus   = 1'b1;
          o_ctl_c.selctl = 1'b1;
          o_ctl_c.drw    = 1'b1;
          // sel[3:2] picks the destination: R0/R1 on the first pass, R2/R3 on the second.
          o_ctl_c.sel = {i_st0, (i_w != W1), 2'b00};
          if (i_w != W1) begin
            o_stop_c = 1'b1;
            o_sst0_c = !i_st0;
            o_cst0_c = i_st0;
          end
        end
        default: o_stop_c = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_seq.sv
// Beat sequencer: FSM, beat register, st0 and interrupt enable.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int unsigned IR_W   = 4,
  parameter int unsigned INT_EN = 1
) (
  input  logic              t3,
  input  logic              clr,
  input  logic [SW_W-1:0]   sw,
  input  logic [IR_W-1:0]   ir,
  input  logic              c,
  input  logic              z,
  input  logic              pulse,
  input  logic              irq,
  output logic [BEAT_W-1:0] w,
  output logic              st0,
  output logic              ie,
  output ctl_t              ctl
);

  state_t            r_state, w_state_nxt;
  logic [BEAT_W-1:0] r_w, w_w_nxt;
  logic              r_st0, w_st0_nxt;
  logic              r_ie, w_ie_nxt;
  logic [SW_W-1:0]   r_sw_cyc, w_sw_cyc_nxt;
  logic [SW_W-1:0]   w_sw_eff;
  logic              w_short, w_long, w_stop, w_sst0, w_cst0, w_set_ie, w_clr_ie;
  logic              w_last, w_take_int;

  // Mode switches act at W1 only; later beats use the mode captured there.
  assign w_sw_eff = (r_state == ST_RUN && r_w != W1) ? r_sw_cyc : sw;

  ctrl_decode #(.IR_W(IR_W), .INT_EN(INT_EN)) u_decode (
    .i_state   (r_state),
    .i_w       (r_w),
    .i_st0     (r_st0),
    .i_sw      (w_sw_eff),
    .i_ir      (ir),
    .i_c       (c),
    .i_z       (z),
    .i_ie      (r_ie),
    .o_ctl_c   (ctl),
    .o_short_c (w_short),
    .o_long_c  (w_long),
    .o_stop_c  (w_stop),
    .o_sst0_c  (w_sst0),
    .o_cst0_c  (w_cst0),
    .o_set_ie_c(w_set_ie),
    .o_clr_ie_c(w_clr_ie)
  );

  assign w_last     = (r_w == W2 && !w_long) || (r_w == W3);
  assign w_take_int = (INT_EN != 0) && r_ie && irq && (w_sw_eff == SW_RUN) &&
                      r_st0 && w_last && !w_stop;

  // Next-state, next-beat and flag update.
  always_comb begin
    w_state_nxt  = r_state;
    w_w_nxt      = r_w;
    w_st0_nxt    = r_st0;
    w_ie_nxt     = r_ie;
    w_sw_cyc_nxt = r_sw_cyc;
    case (r_state)
      ST_HALT: begin
        w_sw_cyc_nxt = sw;
        if (sw != r_sw_cyc) w_st0_nxt = 1'b0;
        if (pulse) begin
          w_state_nxt = ST_RUN;
          w_w_nxt     = W1;
        end
      end
      ST_RUN: begin
        if (r_w == W1) w_sw_cyc_nxt = sw;
        if (w_sst0) w_st0_nxt = 1'b1;
        else if (w_cst0) w_st0_nxt = 1'b0;
        if (w_set_ie) w_ie_nxt = 1'b1;
        else if (w_clr_ie) w_ie_nxt = 1'b0;
        if (w_stop) begin
          w_state_nxt = ST_HALT;
          w_w_nxt     = W_OFF;
        end else if (w_take_int) begin
          w_state_nxt = ST_INTR;
          w_w_nxt     = W1;
        end else begin
          case (r_w)
            W1:      w_w_nxt = w_short ? W1 : W2;
            W2:      w_w_nxt = w_long ? W3 : W1;
            default: w_w_nxt = W1;
          endcase
        end
      end
      ST_INTR: begin
        w_ie_nxt    = 1'b0;
        w_state_nxt = ST_RUN;
        w_w_nxt     = W1;
      end
      default: begin
        w_state_nxt = ST_HALT;
        w_w_nxt     = W_OFF;
      end
    endcase
  end

  // State register with synchronous clear.
  always_ff @(posedge t3) begin
    if (clr) begin
      r_state  <= ST_HALT;
      r_w      <= W_OFF;
      r_st0    <= 1'b0;
      r_ie     <= 1'b0;
      r_sw_cyc <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_w      <= w_w_nxt;
      r_st0    <= w_st0_nxt;
      r_ie     <= (INT_EN != 0) ? w_ie_nxt : 1'b0;
      r_sw_cyc <= w_sw_cyc_nxt;
    end
  end

  assign w   = r_w;
  assign st0 = r_st0;
  assign ie  = r_ie;

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: expected beats queued per cycle, checked at negedge.
module tb_ctrl_seq;
  import ctrl_pkg::*;

  logic       t3 = 1'b0;
  logic       clr, c, z, pulse, irq;
  logic [2:0] sw;
  logic [3:0] ir;
  logic [2:0] w;
  logic       st0, ie;
  ctl_t       ctl;

  int n_checks = 0;
  int n_errors = 0;
  string       q_tag[$];
  logic [31:0] q_exp[$];

  ctrl_seq #(.IR_W(4), .INT_EN(1)) dut (
    .t3(t3), .clr(clr), .sw(sw), .ir(ir), .c(c), .z(z), .pulse(pulse), .irq(irq),
    .w(w), .st0(st0), .ie(ie), .ctl(ctl)
  );

  always #5 t3 = ~t3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Pop one expectation per cycle and compare {w,st0,ie,ctl}.
  always @(negedge t3) begin
    if (q_exp.size() != 0) begin
      string       t;
      logic [31:0] e;
      t = q_tag.pop_front();
      e = q_exp.pop_front();
      check(t, {w, st0, ie, ctl}, e);
    end
  end

  task automatic cyc(input string tag, input logic [2:0] ew, input logic es,
                     input logic ei, input ctl_t ec);
    q_tag.push_back(tag);
    q_exp.push_back({ew, es, ei, ec});
    @(posedge t3);
    #1;
  endtask

  function automatic ctl_t c0();
    return '0;
  endfunction
  function automatic ctl_t c_fetch();
    ctl_t e = '0; e.sbus = 1; e.lpc = 1; return e;
  endfunction
  function automatic ctl_t c_if();
    ctl_t e = '0; e.lir = 1; e.pcinc = 1; return e;
  endfunction
  function automatic ctl_t c_add();
    ctl_t e = '0; e.s = 4'b1001; e.cin = 1; e.abus = 1; e.drw = 1; e.ldz = 1; e.ldc = 1; return e;
  endfunction
  function automatic ctl_t c_ld2();
    ctl_t e = '0; e.s = 4'b1010; e.m = 1; e.abus = 1; e.lar = 1; return e;
  endfunction
  function automatic ctl_t c_ld3();
    ctl_t e = '0; e.mbus = 1; e.drw = 1; return e;
  endfunction
  function automatic ctl_t c_st2();
    ctl_t e = '0; e.s = 4'b1111; e.m = 1; e.abus = 1; e.lar = 1; return e;
  endfunction
  function automatic ctl_t c_st3();
    ctl_t e = '0; e.s = 4'b1010; e.m = 1; e.abus = 1; e.memw = 1; return e;
  endfunction
  function automatic ctl_t c_pcadd();
    ctl_t e = '0; e.pcadd = 1; return e;
  endfunction
  function automatic ctl_t c_intr();
    ctl_t e = '0; e.int_ack = 1; e.lpc_vec = 1; return e;
  endfunction
  function automatic ctl_t c_iret();
    ctl_t e = '0; e.lpc_ret = 1; return e;
  endfunction
  function automatic ctl_t c_wreg(input logic [3:0] s);
    ctl_t e = '0; e.sbus = 1; e.selctl = 1; e.drw = 1; e.sel = s; return e;
  endfunction
  function automatic ctl_t c_rreg(input logic [3:0] s);
    ctl_t e = '0; e.selctl = 1; e.sel = s; return e;
  endfunction
  function automatic ctl_t c_ar();
    ctl_t e = '0; e.sbus = 1; e.lar = 1; return e;
  endfunction
  function automatic ctl_t c_wm();
    ctl_t e = '0; e.sbus = 1; e.memw = 1; e.arinc = 1; return e;
  endfunction
  function automatic ctl_t c_rm();
    ctl_t e = '0; e.mbus = 1; e.arinc = 1; return e;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1; sw = 3'b000; ir = 4'b0000; c = 0; z = 0; pulse = 0; irq = 0;
    repeat (2) @(posedge t3);
    #1;
    clr = 0;
    cyc("reset", W_OFF, 0, 0, c0());

    // ADD from a cold start; a stray pulse in W2 must be ignored
    ir = OP_ADD; pulse = 1; cyc("halt_pulse", W_OFF, 0, 0, c0()); pulse = 0;
    cyc("fetch", W1, 0, 0, c_fetch());
    cyc("add_w1", W1, 1, 0, c_if());
    pulse = 1; cyc("add_w2", W2, 1, 0, c_add()); pulse = 0;

    // LD: three beats
    ir = OP_LD; cyc("ld_w1", W1, 1, 0, c_if());
    cyc("ld_w2", W2, 1, 0, c_ld2());
    cyc("ld_w3", W3, 1, 0, c_ld3());

    // conditional jumps
    ir = OP_JC; c = 0; cyc("jc0_w1", W1, 1, 0, c_if()); cyc("jc0_w2", W2, 1, 0, c0());
    c = 1; cyc("jc1_w1", W1, 1, 0, c_if()); cyc("jc1_w2", W2, 1, 0, c_pcadd()); c = 0;
    ir = OP_JZ; z = 1; cyc("jz1_w1", W1, 1, 0, c_if()); cyc("jz1_w2", W2, 1, 0, c_pcadd()); z = 0;

    // EI, then irq during ADD -> INTR; second irq held off until EI again
    ir = OP_EI; cyc("ei_w1", W1, 1, 0, c_if()); cyc("ei_w2", W2, 1, 0, c0());
    ir = OP_ADD; irq = 1; cyc("irq_w1", W1, 1, 1, c_if()); cyc("irq_w2", W2, 1, 1, c_add());
    cyc("intr", W1, 1, 1, c_intr());
    cyc("post_w1", W1, 1, 0, c_if()); cyc("post_w2", W2, 1, 0, c_add());
    ir = OP_EI; cyc("ei2_w1", W1, 1, 0, c_if()); cyc("ei2_w2", W2, 1, 0, c0());
    ir = OP_ADD; cyc("irq2_w1", W1, 1, 1, c_if()); cyc("irq2_w2", W2, 1, 1, c_add());
    cyc("intr2", W1, 1, 1, c_intr()); irq = 0;

    // IRET re-enables; STP wins over a pending irq; irq ignored in HALT
    ir = OP_IRET; cyc("iret_w1", W1, 1, 0, c_if()); cyc("iret_w2", W2, 1, 0, c_iret());
    ir = OP_STP; irq = 1; cyc("stp_w1", W1, 1, 1, c0()); cyc("stp_w2", W2, 1, 1, c0());
    cyc("stp_halt", W_OFF, 1, 1, c0()); cyc("halt_irq", W_OFF, 1, 1, c0()); irq = 0;

    // DI clears ie at the end of W2
    ir = OP_DI; pulse = 1; cyc("resume", W_OFF, 1, 1, c0()); pulse = 0;
    cyc("di_w1", W1, 1, 1, c_if()); cyc("di_w2", W2, 1, 1, c0());
    ir = OP_STP; cyc("stp2_w1", W1, 1, 0, c0()); cyc("stp2_w2", W2, 1, 0, c0());

    // write registers: two passes, st0 0->1->0
    sw = SW_WREG; cyc("wr_sw", W_OFF, 1, 0, c0());
    pulse = 1; cyc("wr_p1", W_OFF, 0, 0, c0()); pulse = 0;
    cyc("wr_r0", W1, 0, 0, c_wreg(4'b0000)); cyc("wr_r1", W2, 0, 0, c_wreg(4'b0100));
    pulse = 1; cyc("wr_h1", W_OFF, 1, 0, c0()); pulse = 0;
    cyc("wr_r2", W1, 1, 0, c_wreg(4'b1000)); cyc("wr_r3", W2, 1, 0, c_wreg(4'b1100));
    cyc("wr_h2", W_OFF, 0, 0, c0());

    // write memory
    sw = SW_WMEM; pulse = 1; cyc("wm_p1", W_OFF, 0, 0, c0()); pulse = 0;
    cyc("wm_ar", W1, 0, 0, c_ar());
    pulse = 1; cyc("wm_h1", W_OFF, 1, 0, c0()); pulse = 0;
    cyc("wm_dat", W1, 1, 0, c_wm());
    cyc("wm_h2", W_OFF, 1, 0, c0());

    // read memory; mode change in HALT clears st0
    sw = SW_RMEM; pulse = 1; cyc("rm_p1", W_OFF, 1, 0, c0()); pulse = 0;
    cyc("rm_ar", W1, 0, 0, c_ar());
    pulse = 1; cyc("rm_h1", W_OFF, 1, 0, c0()); pulse = 0;
    cyc("rm_dat", W1, 1, 0, c_rm());
    cyc("rm_h2", W_OFF, 1, 0, c0());

    // read registers
    sw = SW_RREG; pulse = 1; cyc("rr_p", W_OFF, 1, 0, c0()); pulse = 0;
    cyc("rr_w1", W1, 0, 0, c_rreg(4'b0001)); cyc("rr_w2", W2, 0, 0, c_rreg(4'b1011));
    cyc("rr_h", W_OFF, 0, 0, c0());

    // clear in W3 of ST with ie set
    sw = SW_RUN; cyc("run_sw", W_OFF, 0, 0, c0());
    ir = OP_EI; pulse = 1; cyc("p3", W_OFF, 0, 0, c0()); pulse = 0;
    cyc("fetch3", W1, 0, 0, c_fetch());
    cyc("ei3_w1", W1, 1, 0, c_if()); cyc("ei3_w2", W2, 1, 0, c0());
    ir = OP_ST; cyc("st_w1", W1, 1, 1, c_if()); cyc("st_w2", W2, 1, 1, c_st2());
    clr = 1; cyc("st_w3", W3, 1, 1, c_st3()); clr = 0;
    cyc("clr_halt", W_OFF, 0, 0, c0());

    @(negedge t3);
    #1;
    check("drain", 32'(q_exp.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
